// File: rtl/nor_seq_arbiter.sv
// Two-requester round-robin front end for a shared W-bit NOR stage; a micro-sequencer
// builds NOR/OR/AND/XOR from single NOR steps. Define NOR_SEQ_FIXED_PRIO_EN for fixed priority.
module nor_seq_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_op0,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [1:0]   req_op1,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_id,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         id_q;
  logic [2:0]   step;
  logic [W-1:0] scratch [4];
  logic         last_grant;

  logic         any_valid;
  logic         win_id;
  logic [1:0]   win_op;
  logic [W-1:0] win_a;
  logic [W-1:0] win_b;
  logic [W-1:0] nor_x;
  logic [W-1:0] nor_y;
  logic [W-1:0] nor_t;
  logic [2:0]   last_idx;
  logic         last_step;

  assign any_valid = |req_valid;

  always_comb begin
    win_id = 1'b0;
`ifdef NOR_SEQ_FIXED_PRIO_EN
    win_id = ~req_valid[0];
`else
    // Prefer whoever did not win last time; fall back to the previous winner.
    if (req_valid[~last_grant]) win_id = ~last_grant;
    else                        win_id = last_grant;
`endif
  end

  assign win_op = win_id ? req_op1 : req_op0;
  assign win_a  = win_id ? req_a1  : req_a0;
  assign win_b  = win_id ? req_b1  : req_b0;

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && any_valid) req_ready = win_id ? 2'b10 : 2'b01;
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand routing for the single NOR evaluated this cycle; scratch[k] holds step k's output.
  always_comb begin
    nor_x    = a_q;
    nor_y    = b_q;
    last_idx = 3'd0;
    case (op_q)
      OP_NOR: begin
        last_idx = 3'd0;
      end
      OP_OR: begin
        last_idx = 3'd1;
        if (step != 3'd0) begin
          nor_x = scratch[0];
          nor_y = scratch[0];
        end
      end
      OP_AND: begin
        last_idx = 3'd2;
        case (step)
          3'd0: begin nor_x = a_q;        nor_y = a_q;        end
          3'd1: begin nor_x = b_q;        nor_y = b_q;        end
          default: begin nor_x = scratch[0]; nor_y = scratch[1]; end
        endcase
      end
      default: begin
        last_idx = 3'd4;
        case (step)
          3'd0: begin nor_x = a_q;        nor_y = b_q;        end
          3'd1: begin nor_x = a_q;        nor_y = scratch[0]; end
          3'd2: begin nor_x = b_q;        nor_y = scratch[0]; end
          3'd3: begin nor_x = scratch[1]; nor_y = scratch[2]; end
          default: begin nor_x = scratch[3]; nor_y = scratch[3]; end
        endcase
      end
    endcase
  end

  assign nor_t     = ~(nor_x | nor_y);
  assign last_step = (step == last_idx);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    if (last_step) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      step       <= 3'd0;
      last_grant <= 1'b1;
      res_data   <= '0;
      res_id     <= 1'b0;
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_q       <= win_op;
            a_q        <= win_a;
            b_q        <= win_b;
            id_q       <= win_id;
            last_grant <= win_id;
            step       <= 3'd0;
          end
        end
        EXEC: begin
          if (last_step) begin
            res_data <= nor_t;
            res_id   <= id_q;
          end else begin
            scratch[step[1:0]] <= nor_t;
            step               <= step + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_seq_arbiter.sv
// Self-checking bench for nor_seq_arbiter: directed vector table, corner sequences,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_nor_seq_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op0;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [1:0]   req_op1;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         busy;

  always #5 clk = ~clk;

  nor_seq_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    case (op)
      2'b00:   return ~(a | b);
      2'b01:   return a | b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op);
    case (op)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int ref_pick(input logic [1:0] v, input int last);
`ifdef NOR_SEQ_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    return v[1 - last] ? (1 - last) : last;
`endif
  endfunction

  // Reference model: phase 0 = waiting, 1 = computing (cycles left in m_cnt), 2 = result held.
  int           m_phase = 0;
  int           m_cnt = 0;
  int           m_last = 1;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_data = '0;
  logic         m_id = 1'b0;
  logic         m_out_id = 1'b0;
  bit           check_en = 1'b0;
  int           dut_acc[$];
  logic [1:0]   exp_rr;
  int           w;

  always @(negedge clk) begin
    exp_rr = 2'b00;
    if (m_phase == 0 && req_valid != 2'b00) exp_rr = 2'b01 << ref_pick(req_valid, m_last);
    if (check_en) begin
      checkOutput("cyc_req_ready", 32'(req_ready), 32'(exp_rr));
      checkOutput("cyc_res_valid", 32'(res_valid), 32'(m_phase == 2));
      checkOutput("cyc_busy", 32'(busy), 32'(m_phase != 0));
      checkOutput("cyc_res_data", 32'(res_data), 32'(m_data));
      checkOutput("cyc_res_id", 32'(res_id), 32'(m_out_id));
    end
    if (req_ready != 2'b00) dut_acc.push_back(req_ready[1] ? 1 : 0);
    if (!rst_n) begin
      m_phase  = 0;
      m_data   = '0;
      m_out_id = 1'b0;
      m_last   = 1;
    end else begin
      case (m_phase)
        0: if (req_valid != 2'b00) begin
          w      = ref_pick(req_valid, m_last);
          m_last = w;
          m_id   = w[0];
          if (w == 0) begin
            m_res = ref_result(req_op0, req_a0, req_b0);
            m_cnt = ref_latency(req_op0);
          end else begin
            m_res = ref_result(req_op1, req_a1, req_b1);
            m_cnt = ref_latency(req_op1);
          end
          m_phase = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase  = 2;
            m_data   = m_res;
            m_out_id = m_id;
          end
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  typedef struct {
    logic         id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  // Issue one request from a single requester, wait for acceptance and then for the result.
  task automatic applyStimulus(input vec_t v, output int lat, output bit ok);
    if (v.id == 1'b0) begin req_op0 = v.op; req_a0 = v.a; req_b0 = v.b; end
    else              begin req_op1 = v.op; req_a1 = v.a; req_b1 = v.b; end
    req_valid = v.id ? 2'b10 : 2'b01;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[v.id]) ok = 1'b1;
    end
    if (!ok) begin
      req_valid = 2'b00;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_op0 = 2'($urandom); req_a0 = 4'($urandom); req_b0 = 4'($urandom);
    req_op1 = 2'($urandom); req_a1 = 4'($urandom); req_b1 = 4'($urandom);
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!res_valid && lat < 12);
  endtask

  task automatic drainResult();
    res_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    res_ready = 1'b0;
    checkOutput("drain_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int         lat;
    bit         ok;
    bit         seen;
    logic [1:0] acc;
    int         exp_order[4];

    rst_n = 1'b0; res_ready = 1'b0; req_valid = 2'b00;
    req_op0 = 2'b00; req_a0 = '0; req_b0 = '0;
    req_op1 = 2'b00; req_a1 = '0; req_b1 = '0;

    vecs[0] = '{1'b0, 2'b11, 4'b1100, 4'b1010, 4'b0110, 5};
    vecs[1] = '{1'b1, 2'b10, 4'b1100, 4'b1010, 4'b1000, 3};
    vecs[2] = '{1'b1, 2'b01, 4'b1100, 4'b1010, 4'b1110, 2};
    vecs[3] = '{1'b1, 2'b00, 4'b1100, 4'b1010, 4'b0001, 1};
    vecs[4] = '{1'b0, 2'b10, 4'b1111, 4'b1111, 4'b1111, 3};
    vecs[5] = '{1'b1, 2'b11, 4'b1111, 4'b0000, 4'b1111, 5};
    vecs[6] = '{1'b0, 2'b00, 4'b0000, 4'b0000, 4'b1111, 1};
    vecs[7] = '{1'b0, 2'b01, 4'b0000, 4'b0000, 4'b0000, 2};

    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;
    checkOutput("reset_res_valid", 32'(res_valid), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_res_data", 32'(res_data), 32'(0));
    checkOutput("reset_res_id", 32'(res_id), 32'(0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], lat, ok);
      checkOutput($sformatf("vec%0d_accept", i), 32'(ok), 32'(1));
      if (ok) begin
        checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        checkOutput($sformatf("vec%0d_data", i), 32'(res_data), 32'(vecs[i].exp));
        checkOutput($sformatf("vec%0d_id", i), 32'(res_id), 32'(vecs[i].id));
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      checkOutput($sformatf("vec%0d_release", i), 32'(res_valid), 32'(0));
    end

    // Result held in DONE while the other requester waits.
    applyStimulus('{1'b0, 2'b01, 4'b0101, 4'b0000, 4'b0101, 2}, lat, ok);
    req_op1 = 2'b00; req_a1 = 4'b0011; req_b1 = 4'b0101;
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("hold_res_valid", 32'(res_valid), 32'(1));
      checkOutput("hold_res_data", 32'(res_data), 32'(4'b0101));
      checkOutput("hold_res_id", 32'(res_id), 32'(0));
      checkOutput("hold_req_ready", 32'(req_ready), 32'(0));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("hold_release_accept", 32'(req_ready), 32'(2'b10));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drainResult();

    // Reset in the middle of an XOR aborts it; afterwards requester 0 wins first.
    req_op0 = 2'b11; req_a0 = 4'b1100; req_b0 = 4'b1010;
    req_valid = 2'b01;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort_res_valid", 32'(res_valid), 32'(0));
    checkOutput("abort_busy", 32'(busy), 32'(0));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    checkOutput("abort_no_result", 32'(seen), 32'(0));

    dut_acc.delete();
    req_op0 = 2'b00; req_a0 = 4'b1001; req_b0 = 4'b0011;
    req_op1 = 2'b00; req_a1 = 4'b0110; req_b1 = 4'b0001;
    req_valid = 2'b11;
    res_ready = 1'b1;
    for (int i = 0; i < 40 && dut_acc.size() < 4; i++) @(posedge clk);
    #1;
    req_valid = 2'b00;
`ifdef NOR_SEQ_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    checkOutput("contend_accepts", 32'(dut_acc.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++)
      if (i < dut_acc.size())
        checkOutput($sformatf("contend_grant%0d", i), 32'(dut_acc[i]), 32'(exp_order[i]));
    drainResult();

    // Randomized traffic; the per-cycle model does the checking.
    acc = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (!req_valid[0] || acc[0]) begin
        req_valid[0] = ($urandom_range(0, 1) == 1);
        req_op0 = 2'($urandom); req_a0 = 4'($urandom); req_b0 = 4'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req_valid[0] = 1'b0;
      end
      if (!req_valid[1] || acc[1]) begin
        req_valid[1] = ($urandom_range(0, 1) == 1);
        req_op1 = 2'($urandom); req_a1 = 4'($urandom); req_b1 = 4'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req_valid[1] = 1'b0;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
